// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline controller for the five-stage MIPS core.
//   * Encodes per-stage stall requests into the 6-bit stall vector used by the
//     PC register and the if_id / id_ex / ex_mem / mem_wb latches.
//   * Raises flush and supplies the redirect PC when an exception or eret
//     commits in MEM.
//   * Watches MEM bus stalls and turns a hung access into a bus-timeout flush.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous active-low reset
//   stallreq_id   in   1   load-use hazard request from ID
//   stallreq_ex   in   1   mult/div busy request from EX
//   stallreq_mem  in   1   data-bus wait request from MEM
//   excepttype_i  in  32   exception committed in MEM (0 = none, 0xe = eret)
//   cp0_epc_i     in  32   current CP0 EPC
//   stall         out  6   [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   flush         out  1   clear all pipeline latches this cycle
//   new_pc        out 32   redirect target, 0 unless flush is high
//   bus_timeout   out  1   one-cycle pulse when the watchdog fires
//
// All outputs are combinational from the inputs and the current state so the
// latches react on the same clock edge.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int          TIMEOUT     = 255,
    parameter int          RECOVER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_timeout
);

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [1:0]  RCNT_INIT = 2'(RECOVER_CYC - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rcnt_q,  rcnt_d;
    logic [7:0]  wcnt_q,  wcnt_d;

    logic [5:0]  stall_s;
    logic        flush_s;
    logic [31:0] new_pc_s;
    logic        bus_timeout_s;
    logic        exc_s;
    logic        timeout_s;

    // Stall encoding: a stage stalls itself and everything upstream of it.
    function automatic logic [5:0] encode_stall(input logic req_id,
                                                input logic req_ex,
                                                input logic req_mem);
        logic [5:0] v;
        if (req_mem) begin
            v = 6'b011111;
        end else if (req_ex) begin
            v = 6'b001111;
        end else if (req_id) begin
            v = 6'b000111;
        end else begin
            v = 6'b000000;
        end
        return v;
    endfunction

    // Watchdog increment that sticks at the top value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    assign exc_s     = (excepttype_i != 32'h0000_0000);
    assign timeout_s = stallreq_mem && (wcnt_q == WD_LAST);

    // Next-state and combinational output decode.
    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        wcnt_d        = wcnt_q;
        stall_s       = 6'b000000;
        flush_s       = 1'b0;
        new_pc_s      = 32'h0000_0000;
        bus_timeout_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_s) begin
                    // An exception always wins over a simultaneous timeout.
                    flush_s  = 1'b1;
                    if (excepttype_i == ERET_CODE) begin
                        new_pc_s = cp0_epc_i;
                    end else begin
                        new_pc_s = EXC_VECTOR;
                    end
                    state_d = ST_RECOVER;
                    rcnt_d  = RCNT_INIT;
                    wcnt_d  = 8'd0;
                end else if (timeout_s) begin
                    flush_s       = 1'b1;
                    bus_timeout_s = 1'b1;
                    new_pc_s      = EXC_VECTOR;
                    state_d       = ST_RECOVER;
                    rcnt_d        = RCNT_INIT;
                    wcnt_d        = 8'd0;
                end else begin
                    stall_s = encode_stall(stallreq_id, stallreq_ex, stallreq_mem);
                    if (stallreq_mem) begin
                        wcnt_d = sat_inc8(wcnt_q);
                    end else begin
                        wcnt_d = 8'd0;
                    end
                end
            end
            ST_RECOVER: begin
                // Only bubbles are in flight; every request is ignored.
                wcnt_d = 8'd0;
                if (rcnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                rcnt_d  = 2'd0;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // State, recovery counter and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            rcnt_q  <= 2'd0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Outputs are held at zero for the whole time reset is asserted.
    assign stall       = rst ? stall_s       : 6'b000000;
    assign flush       = rst ? flush_s       : 1'b0;
    assign new_pc      = rst ? new_pc_s      : 32'h0000_0000;
    assign bus_timeout = rst ? bus_timeout_s : 1'b0;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        sid, sex, smem;
    logic [31:0] exc, epc;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] pc_a, pc_b;
    logic        to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance A: short watchdog, one recovery cycle.
    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .TIMEOUT(4), .RECOVER_CYC(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .bus_timeout(to_a)
    );

    // Instance B: three recovery cycles for the mid-RECOVER reset case.
    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .TIMEOUT(255), .RECOVER_CYC(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .bus_timeout(to_b)
    );

    typedef struct {
        logic        rst;
        logic        id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic r, logic i, logic e, logic m,
                                logic [31:0] x, logic [31:0] p,
                                logic [5:0] s, logic f, logic [31:0] np, logic t);
        vec_t v;
        v.rst = r; v.id = i; v.ex = e; v.mem = m; v.exc = x; v.epc = p;
        v.stall = s; v.flush = f; v.pc = np; v.to = t;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(logic i, logic e, logic m, logic [31:0] x, logic [31:0] p);
        sid = i; sex = e; smem = m; exc = x; epc = p;
    endtask

    localparam logic [31:0] V  = 32'h0000_0020;
    localparam logic [31:0] ER = 32'h0000_000e;
    localparam logic [31:0] EP = 32'h0000_1234;

    initial begin
        vec_t v, e;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with everything asserted: outputs must stay 0.
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h1, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, ER,    EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        // Request mix.
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, EP, 6'b000111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, EP, 6'b001111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, EP, 6'b011111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        // Exception redirect, one RECOVER cycle, then ex stall honoured.
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h1, EP, 6'b000000, 1'b1, V,     1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, EP, 6'b001111, 1'b0, 32'h0, 1'b0));
        // eret, then an exception held into RECOVER gives no flush.
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, ER,    EP, 6'b000000, 1'b1, EP,    1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, ER,    EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        // Watchdog: 3 stalled, 1 idle, then 4 stalled -> pulse on the 4th.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b011111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b011111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b000000, 1'b1, V,     1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        // Watchdog restarted from 0: three more stalled cycles, then pulse again.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b011111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b000000, 1'b1, V,     1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, EP, 6'b000000, 1'b0, 32'h0, 1'b0));
        // Collision: eret on the cycle the watchdog would fire.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h5678, 6'b011111, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, ER, 32'h5678, 6'b000000, 1'b1, 32'h5678, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5678, 6'b000000, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5678, 6'b000111, 1'b0, 32'h0, 1'b0));
        // Ordinary exception during a mem stall uses the vector.
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, EP, 6'b000000, 1'b1, V,     1'b0));

        @(posedge clk); #1;
        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            rst_a = v.rst;
            drive(v.id, v.ex, v.mem, v.exc, v.epc);
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d.stall", n), {26'h0, stall_a}, {26'h0, e.stall});
            chk($sformatf("v%0d.flush", n), {31'h0, flush_a}, {31'h0, e.flush});
            chk($sformatf("v%0d.new_pc", n), pc_a, e.pc);
            chk($sformatf("v%0d.bus_timeout", n), {31'h0, to_a}, {31'h0, e.to});
            @(posedge clk); #1;
        end

        // Mid-RECOVER asynchronous reset on instance B (RECOVER_CYC=3).
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, EP);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h1, EP);
        @(negedge clk);
        chk("b.exc_flush", {31'h0, flush_b}, 32'h1);
        chk("b.exc_pc", pc_b, V);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, EP);
        @(negedge clk);
        chk("b.recover1_stall", {26'h0, stall_b}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b.recover2_stall", {26'h0, stall_b}, 32'h0);
        #1;
        rst_b = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h1, EP);
        #1;
        chk("b.in_reset_stall", {26'h0, stall_b}, 32'h0);
        chk("b.in_reset_flush", {31'h0, flush_b}, 32'h0);
        chk("b.in_reset_pc", pc_b, 32'h0);
        rst_b = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, EP);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b.after_reset_stall", {26'h0, stall_b}, 32'h0000_0007);
        chk("b.after_reset_flush", {31'h0, flush_b}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage MIPS core. It turns the per-stage stall requests into the 6-bit `stall` vector consumed by the PC register and every pipeline latch (if_id, id_ex, ex_mem, mem_wb). It raises `flush` and supplies the redirect PC when an exception or `eret` commits in MEM. It also runs a watchdog on MEM bus stalls and converts a hung access into a bus-timeout exception.

## Interface

Parameters:
- `EXC_VECTOR`, default 32'h0000_0020: redirect PC for all exceptions except `eret`.
- `TIMEOUT`, default 255: number of consecutive MEM-stall cycles that triggers a bus timeout. Legal range is 2..255.
- `RECOVER_CYC`, default 1: number of cycles the block stays in RECOVER after a flush. Legal range is 1..3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stallreq_id`  in  1  load-use hazard request from ID.
- `stallreq_ex`  in  1  multi-cycle mult/div busy request from EX.
- `stallreq_mem`  in  1  data-bus wait request from MEM.
- `excepttype_i`  in  32  exception committed in MEM; zero means none; 32'h0000_000e means `eret`.
- `cp0_epc_i`  in  32  current CP0 EPC.
- `stall`  out  6  bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.
- `flush`  out  1  clears all latches this cycle.
- `new_pc`  out  32  redirect target; valid only while `flush`=1, otherwise 0.
- `bus_timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation

- FSM has two states: RUN and RECOVER. A down-counter `rcnt` (2 bits) tracks RECOVER length. An up-counter `wcnt` (8 bits) is the watchdog.
- Stall encoding applies in RUN only. Priority is mem > ex > id.
  - `stallreq_mem` gives 6'b011111.
  - Otherwise `stallreq_ex` gives 6'b001111.
  - Otherwise `stallreq_id` gives 6'b000111.
  - Otherwise 6'b000000.
- Exception in RUN with `excepttype_i` != 0:
  - Outputs (same cycle, combinational): `flush`=1, `stall`=0.
  - `new_pc` = `cp0_epc_i` if `excepttype_i` = 32'h0000_000e, else `EXC_VECTOR`.
  - Next state: RECOVER, with `rcnt` = `RECOVER_CYC`-1. `wcnt` is cleared.
- Watchdog:
  - In RUN, `wcnt` increments when `stallreq_mem`=1 and clears when `stallreq_mem`=0.
  - When `wcnt` = `TIMEOUT`-1, `stallreq_mem`=1 and `excepttype_i`=0, that cycle produces `bus_timeout`=1, `flush`=1, `stall`=0 and `new_pc`=`EXC_VECTOR`.
  - The block then enters RECOVER exactly as for an exception, and `wcnt` clears.
- RECOVER state:
  - Outputs: `stall`=0, `flush`=0, `new_pc`=0.
  - `excepttype_i` and all stall requests are ignored; the pipeline holds only bubbles.
  - `wcnt` is held at 0.
  - When `rcnt`=0, next state is RUN; otherwise `rcnt` decrements.
- Simultaneous events:
  - An exception beats a timeout on the same cycle, so `bus_timeout` stays 0.
  - An exception or timeout overrides any stall request. The `flush` cycle always has `stall`=0.
- Width rule: `wcnt` saturates at 255 and never wraps. The `TIMEOUT` range guarantees it fires before that.

## Timing

- Reset state: RUN, `wcnt`=0, `rcnt`=0. While `rst`=0, all outputs are forced to 0 regardless of inputs.
- Asserting `rst` mid-flush or mid-RECOVER returns the FSM to RUN immediately (asynchronously).
- `stall`, `flush`, `new_pc` and `bus_timeout` are combinational from the inputs and the current state, so the latches see them at the same clock edge (0-cycle latency).
- `flush` is high for exactly 1 cycle per event.
- After a flush, requests are ignored for exactly `RECOVER_CYC` cycles. They are honoured again in the cycle after the last RECOVER cycle.
- With `TIMEOUT`=T and `stallreq_mem` held high from cycle 0 in RUN, `bus_timeout` fires in cycle T-1, i.e. on the T-th stalled cycle.

## Test plan

- Reset, then a request mix: with `rst`=0 and all requests high, every output is 0. Release reset; `stallreq_id`=1 alone gives `stall`=6'b000111; `stallreq_ex`+`stallreq_id` gives 6'b001111; all three give 6'b011111.
- Exception redirect: in RUN, drive `excepttype_i`=32'h1 with `stallreq_ex`=1. The same cycle shows `flush`=1, `stall`=0, `new_pc`=32'h20. The next cycle (RECOVER, `RECOVER_CYC`=1) shows `stall`=0 with `stallreq_ex` still high. The cycle after that shows `stall`=6'b001111.
- `eret`: drive `excepttype_i`=32'h0000_000e with `cp0_epc_i`=32'h0000_1234. Expect `flush`=1 and `new_pc`=32'h0000_1234.
- Watchdog, with `TIMEOUT`=4:
  - `stallreq_mem` high for 3 cycles, low for 1, then high for 4.
  - The first burst produces no pulse.
  - In the second burst, `bus_timeout`=1, `flush`=1 and `new_pc`=32'h20 on the 4th cycle. Then RECOVER, then `wcnt` restarts from 0.
- Collision: on the same cycle the watchdog would fire, drive `excepttype_i`=32'h0000_000e. Expect `bus_timeout`=0 and `new_pc`=`cp0_epc_i`. An exception presented during RECOVER produces no `flush`.
- Asynchronous reset mid-RECOVER: with `RECOVER_CYC`=3, pulse `rst` low in the 2nd RECOVER cycle. Outputs drop to 0 immediately. After release, `stallreq_id`=1 gives `stall`=6'b000111 on the first cycle.
